// File: rtl/stage_sched.sv
// stage_sched: walks the classifier ROM cascade for one window.
// Optional: define STAGE_SCHED_PERF_EN to add perf_cycles_o.
`ifndef THRESHOLD
`define THRESHOLD 2'd0
`endif
`ifndef LEFT_VAL
`define LEFT_VAL 2'd1
`endif
`ifndef RIGHT_VAL
`define RIGHT_VAL 2'd2
`endif

module stage_sched #(
  parameter int STAGE_CNT = 22,
  parameter int ROM_AW    = 14,
  parameter int THR_LAT   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              win_start_i,
  output logic              win_busy_o,
  output logic              rom_rd_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_rdata_i,
  output logic              new_stage_o,
  output logic [31:0]       thresholds_o,
  output logic [1:0]        thresholds_type_o,
  output logic              thresholds_val_o,
  output logic              feat_start_o,
  output logic [15:0]       feat_idx_o,
  input  logic [31:0]       stage_sum_i,
  input  logic              stage_sum_val_i,
`ifdef STAGE_SCHED_PERF_EN
  output logic [31:0]       perf_cycles_o,
`endif
  output logic              result_val_o,
  output logic              result_face_o,
  output logic [7:0]        result_stage_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_N, S_HDR_THR, S_LD_THR,
    S_LD_LEFT, S_LD_RIGHT, S_THR_ISSUE, S_THR_WAIT,
    S_FEAT_START, S_FEAT_WAIT, S_STAGE_CHK, S_DONE
  } state_t;

  state_t r_st, w_st_nx;
  logic              r_ph;
  logic              w_rd_st;
  logic [ROM_AW-1:0] r_addr;
  logic [15:0]       r_n;
  logic [15:0]       r_fcnt;
  logic [15:0]       w_fcnt_inc;
  logic [15:0]       r_feat_idx;
  logic [7:0]        r_stage;
  logic [7:0]        r_tw;
  logic [31:0]       r_sthr;
  logic [31:0]       r_fthr;
  logic [31:0]       r_sum;
  logic [31:0]       r_thr;
  logic [1:0]        r_thr_type;
  logic              r_thr_val;
  logic              r_new_stage;
  logic              r_feat_start;
  logic              r_busy;
  logic              r_pass;
  logic              r_res_val;
  logic              r_face;
  logic [7:0]        r_res_stage;
  logic              w_last_feat;
  logic              w_last_stage;
  logic              w_sz, w_tz, w_ss, w_ts;
  logic              w_ge;

  assign w_fcnt_inc   = r_fcnt + 16'd1;
  assign w_last_feat  = (w_fcnt_inc == r_n);
  assign w_last_stage = (r_stage == 8'(STAGE_CNT - 1));

  // zero magnitudes are treated as positive so +0 == -0
  assign w_sz = (r_sum[30:0] == 31'd0);
  assign w_tz = (r_sthr[30:0] == 31'd0);
  assign w_ss = r_sum[31] & ~w_sz;
  assign w_ts = r_sthr[31] & ~w_tz;

  always_comb begin
    w_ge = 1'b0;
    if (w_ss != w_ts)
      w_ge = w_ts;
    else if (!w_ss)
      w_ge = (r_sum[30:0] >= r_sthr[30:0]);
    else
      w_ge = (r_sum[30:0] <= r_sthr[30:0]);
  end

  always_comb begin
    w_st_nx = r_st;
    w_rd_st = 1'b0;
    unique case (r_st)
      S_IDLE:
        if (win_start_i) w_st_nx = S_HDR_N;
      S_HDR_N: begin
        w_rd_st = 1'b1;
        if (r_ph) w_st_nx = S_HDR_THR;
      end
      S_HDR_THR: begin
        w_rd_st = 1'b1;
        if (r_ph)
          w_st_nx = (r_n == 16'd0) ? S_STAGE_CHK : S_LD_THR;
      end
      S_LD_THR: begin
        w_rd_st = 1'b1;
        if (r_ph) w_st_nx = S_LD_LEFT;
      end
      S_LD_LEFT: begin
        w_rd_st = 1'b1;
        if (r_ph) w_st_nx = S_LD_RIGHT;
      end
      S_LD_RIGHT: begin
        w_rd_st = 1'b1;
        if (r_ph) w_st_nx = S_THR_ISSUE;
      end
      S_THR_ISSUE:
        w_st_nx = S_THR_WAIT;
      S_THR_WAIT:
        if (r_tw == 8'(THR_LAT)) w_st_nx = S_FEAT_START;
      S_FEAT_START:
        w_st_nx = S_FEAT_WAIT;
      S_FEAT_WAIT:
        if (stage_sum_val_i)
          w_st_nx = w_last_feat ? S_STAGE_CHK : S_LD_THR;
      S_STAGE_CHK:
        w_st_nx = (!w_ge || w_last_stage) ? S_DONE : S_HDR_N;
      S_DONE:
        w_st_nx = S_IDLE;
      default:
        w_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_st         <= S_IDLE;
      r_ph         <= 1'b0;
      r_addr       <= '0;
      r_n          <= '0;
      r_fcnt       <= '0;
      r_feat_idx   <= '0;
      r_stage      <= '0;
      r_tw         <= '0;
      r_sthr       <= '0;
      r_fthr       <= '0;
      r_sum        <= '0;
      r_thr        <= '0;
      r_thr_type   <= '0;
      r_thr_val    <= 1'b0;
      r_new_stage  <= 1'b0;
      r_feat_start <= 1'b0;
      r_busy       <= 1'b0;
      r_pass       <= 1'b0;
      r_res_val    <= 1'b0;
      r_face       <= 1'b0;
      r_res_stage  <= '0;
    end else begin
      r_st         <= w_st_nx;
      r_ph         <= w_rd_st & ~r_ph;
      r_thr_val    <= 1'b0;
      r_new_stage  <= 1'b0;
      r_feat_start <= 1'b0;
      r_res_val    <= 1'b0;
      if (w_rd_st && !r_ph)
        r_addr <= r_addr + 1'b1;
      unique case (r_st)
        S_IDLE:
          if (win_start_i) begin
            r_addr      <= '0;
            r_stage     <= '0;
            r_feat_idx  <= '0;
            r_busy      <= 1'b1;
            r_face      <= 1'b0;
            r_res_stage <= '0;
          end
        S_HDR_N:
          if (!r_ph) begin
            r_new_stage <= 1'b1;
            r_sum       <= '0;
          end else begin
            r_n    <= rom_rdata_i[15:0];
            r_fcnt <= '0;
          end
        S_HDR_THR:
          if (r_ph) r_sthr <= rom_rdata_i;
        S_LD_THR:
          if (r_ph) r_fthr <= rom_rdata_i;
        S_LD_LEFT:
          if (r_ph) begin
            r_thr      <= rom_rdata_i;
            r_thr_type <= `LEFT_VAL;
            r_thr_val  <= 1'b1;
          end
        S_LD_RIGHT:
          if (r_ph) begin
            r_thr      <= rom_rdata_i;
            r_thr_type <= `RIGHT_VAL;
            r_thr_val  <= 1'b1;
          end
        S_THR_ISSUE: begin
          r_thr      <= r_fthr;
          r_thr_type <= `THRESHOLD;
          r_thr_val  <= 1'b1;
          r_tw       <= '0;
        end
        S_THR_WAIT:
          r_tw <= r_tw + 8'd1;
        S_FEAT_START:
          r_feat_start <= 1'b1;
        S_FEAT_WAIT:
          if (stage_sum_val_i) begin
            r_sum      <= stage_sum_i;
            r_feat_idx <= r_feat_idx + 16'd1;
            r_fcnt     <= w_fcnt_inc;
          end
        S_STAGE_CHK: begin
          r_pass <= w_ge;
          if (w_ge && !w_last_stage)
            r_stage <= r_stage + 8'd1;
        end
        S_DONE: begin
          r_res_val   <= 1'b1;
          r_face      <= r_pass;
          r_res_stage <= r_stage;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef STAGE_SCHED_PERF_EN
  logic [31:0] r_perf;

  // preset to 2: the accept cycle plus the first cycle it is visible
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_perf <= '0;
    else if (r_st == S_IDLE && win_start_i)
      r_perf <= 32'd2;
    else if (r_busy && r_perf != 32'hFFFF_FFFF)
      r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles_o = r_perf;
`endif

  assign win_busy_o        = r_busy;
  assign rom_rd_o          = w_rd_st & ~r_ph;
  assign rom_addr_o        = r_addr;
  assign new_stage_o       = r_new_stage;
  assign thresholds_o      = r_thr;
  assign thresholds_type_o = r_thr_type;
  assign thresholds_val_o  = r_thr_val;
  assign feat_start_o      = r_feat_start;
  assign feat_idx_o        = r_feat_idx;
  assign result_val_o      = r_res_val;
  assign result_face_o     = r_face;
  assign result_stage_o    = r_res_stage;

endmodule

// File: tb/tb_stage_sched.sv
// tb_stage_sched: directed windows against a behavioural ROM
// and stage-sum datapath model.
`ifndef THRESHOLD
`define THRESHOLD 2'd0
`endif
`ifndef LEFT_VAL
`define LEFT_VAL 2'd1
`endif
`ifndef RIGHT_VAL
`define RIGHT_VAL 2'd2
`endif

module tb_stage_sched;
  localparam int SC = 3;
  localparam int AW = 14;
  localparam int TL = 5;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          win_start_i;
  logic          win_busy_o;
  logic          rom_rd_o;
  logic [AW-1:0] rom_addr_o;
  logic [31:0]   rom_rdata_i = '0;
  logic          new_stage_o;
  logic [31:0]   thresholds_o;
  logic [1:0]    thresholds_type_o;
  logic          thresholds_val_o;
  logic          feat_start_o;
  logic [15:0]   feat_idx_o;
  logic [31:0]   stage_sum_i = '0;
  logic          stage_sum_val_i = 1'b0;
  logic          result_val_o;
  logic          result_face_o;
  logic [7:0]    result_stage_o;
`ifdef STAGE_SCHED_PERF_EN
  logic [31:0]   perf_cycles_o;
`endif

  always #5 clk = ~clk;

  stage_sched #(.STAGE_CNT(SC), .ROM_AW(AW), .THR_LAT(TL)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .win_start_i       (win_start_i),
    .win_busy_o        (win_busy_o),
    .rom_rd_o          (rom_rd_o),
    .rom_addr_o        (rom_addr_o),
    .rom_rdata_i       (rom_rdata_i),
    .new_stage_o       (new_stage_o),
    .thresholds_o      (thresholds_o),
    .thresholds_type_o (thresholds_type_o),
    .thresholds_val_o  (thresholds_val_o),
    .feat_start_o      (feat_start_o),
    .feat_idx_o        (feat_idx_o),
    .stage_sum_i       (stage_sum_i),
    .stage_sum_val_i   (stage_sum_val_i),
`ifdef STAGE_SCHED_PERF_EN
    .perf_cycles_o     (perf_cycles_o),
`endif
    .result_val_o      (result_val_o),
    .result_face_o     (result_face_o),
    .result_stage_o    (result_stage_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] rom [64];
  logic [31:0] sums [4];
  logic        stray_arm = 1'b0;
  int          win_id = 0;

  int          mon_id = 0;
  int          cyc = 0;
  int          nrd, nthr, nfs, nns, nres, novl;
  logic [31:0] max_addr, first_addr, thr_cyc, fs_cyc;
  logic [31:0] fs_idx0, fs_idx_last, rface, rstage;
  logic [1:0]  tq_type [3];
  logic [31:0] tq_val [3];
  int          dp_cnt = 0;
  int          st_cnt = 0;
  logic [1:0]  dp_idx = '0;

  always @(negedge clk) begin
    if (win_id != mon_id) begin
      mon_id = win_id;
      nrd = 0; nthr = 0; nfs = 0; nns = 0; nres = 0; novl = 0;
      max_addr = 0; first_addr = '1; thr_cyc = 0; fs_cyc = 0;
      fs_idx0 = '1; fs_idx_last = '1; rface = '1; rstage = '1;
    end
    cyc++;
    if (rom_rd_o) begin
      nrd++;
      if (nrd == 1) first_addr = 32'(rom_addr_o);
      if (32'(rom_addr_o) > max_addr) max_addr = 32'(rom_addr_o);
    end
    if (thresholds_val_o) begin
      nthr++;
      if (nthr <= 3) begin
        tq_type[nthr-1] = thresholds_type_o;
        tq_val[nthr-1]  = thresholds_o;
      end
      if (nthr == 3) thr_cyc = 32'(cyc);
    end
    if (feat_start_o) begin
      nfs++;
      if (nfs == 1) begin
        fs_cyc  = 32'(cyc);
        fs_idx0 = 32'(feat_idx_o);
      end
      fs_idx_last = 32'(feat_idx_o);
    end
    if (new_stage_o) nns++;
    if (thresholds_val_o && feat_start_o) novl++;
    if (result_val_o) begin
      nres++;
      rface  = 32'(result_face_o);
      rstage = 32'(result_stage_o);
    end
    if (!rst_i) begin
      dp_cnt = 0;
      st_cnt = 0;
      stage_sum_val_i = 1'b0;
    end else begin
      stage_sum_val_i = 1'b0;
      if (rom_rd_o) rom_rdata_i = rom[rom_addr_o[5:0]];
      if (feat_start_o) begin
        dp_cnt = 3;
        dp_idx = feat_idx_o[1:0];
      end else if (dp_cnt != 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          stage_sum_val_i = 1'b1;
          stage_sum_i     = sums[dp_idx];
        end
      end
      if (stray_arm && thresholds_val_o &&
          thresholds_type_o == `THRESHOLD) begin
        st_cnt = 2;
      end else if (st_cnt != 0) begin
        st_cnt--;
        if (st_cnt == 0) begin
          stage_sum_val_i = 1'b1;
          stage_sum_i     = 32'hC000_0000;
        end
      end
    end
  end

  task automatic clr_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0007;
    for (int i = 0; i < 4; i++) sums[i] = '0;
  endtask

  task automatic feat(input int a, input logic [31:0] t,
                      input logic [31:0] l, input logic [31:0] r);
    rom[a] = t; rom[a+1] = l; rom[a+2] = r;
  endtask

  // stage0 N=1 passes 1.0>=0.5, stages 1 and 2 are N=0 with T=+0
  task automatic load_w1();
    clr_rom();
    rom[0] = 1; rom[1] = 32'h3F00_0000;
    feat(2, 32'h3F00_0000, 32'h3F80_0000, 32'hBF80_0000);
    rom[5] = 0; rom[6] = 0;
    rom[7] = 0; rom[8] = 0;
    sums[0] = 32'h3F80_0000;
  endtask

  // stage1 rejects: -1.0 < -0.5
  task automatic load_w2();
    clr_rom();
    rom[0] = 1; rom[1] = 32'h3F00_0000;
    feat(2, 32'h3F00_0000, 32'h3F80_0000, 32'hBF80_0000);
    rom[5] = 1; rom[6] = 32'hBF00_0000;
    feat(7, 32'h3E80_0000, 32'h4000_0000, 32'hC000_0000);
    rom[10] = 0; rom[11] = 0;
    sums[0] = 32'h3F80_0000;
    sums[1] = 32'hBF80_0000;
  endtask

  // -0>=+0 pass, 1.0+ulp>=1.0 pass, -2.0<-1.0 reject at stage 2
  task automatic load_w3();
    clr_rom();
    rom[0] = 1; rom[1] = 32'h0000_0000;
    feat(2, 32'h1, 32'h2, 32'h3);
    rom[5] = 1; rom[6] = 32'h3F80_0000;
    feat(7, 32'h4, 32'h5, 32'h6);
    rom[10] = 1; rom[11] = 32'hBF80_0000;
    feat(12, 32'h7, 32'h8, 32'h9);
    sums[0] = 32'h8000_0000;
    sums[1] = 32'h3F80_0001;
    sums[2] = 32'hC000_0000;
  endtask

  task automatic start_win();
    win_id++;
    @(negedge clk);
    win_start_i = 1'b1;
    @(negedge clk);
    win_start_i = 1'b0;
    check("busy_after_start", 32'(win_busy_o), 32'd1);
  endtask

  task automatic run_win(input bit disturb);
    int n;
    stray_arm = disturb;
    start_win();
    if (disturb) begin
      repeat (4) @(negedge clk);
      win_start_i = 1'b1;
      @(negedge clk);
      win_start_i = 1'b0;
    end
    n = 0;
    while (!result_val_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("result_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    stray_arm = 1'b0;
    check("busy_after_done", 32'(win_busy_o), 32'd0);
    check("result_pulses", 32'(nres), 32'd1);
    check("face_hold", 32'(result_face_o), rface);
  endtask

  task automatic chk_w1(input string p);
    check({p, "_face"}, rface, 32'd1);
    check({p, "_stage"}, rstage, 32'd2);
    check({p, "_reads"}, 32'(nrd), 32'd9);
    check({p, "_max_addr"}, max_addr, 32'd8);
    check({p, "_feat_starts"}, 32'(nfs), 32'd1);
    check({p, "_new_stage"}, 32'(nns), 32'd3);
    check({p, "_first_addr"}, first_addr, 32'd0);
    check({p, "_feat_idx"}, fs_idx0, 32'd0);
  endtask

  task automatic chk_zero(input string p);
    check({p, "_ctl"}, 32'({win_busy_o, rom_rd_o, new_stage_o,
      thresholds_val_o, feat_start_o, result_val_o, result_face_o}),
      32'd0);
    check({p, "_addr"}, 32'(rom_addr_o), 32'd0);
    check({p, "_thr"}, thresholds_o, 32'd0);
    check({p, "_type"}, 32'(thresholds_type_o), 32'd0);
    check({p, "_feat_idx"}, 32'(feat_idx_o), 32'd0);
    check({p, "_res_stage"}, 32'(result_stage_o), 32'd0);
  endtask

  initial begin
    int n;
    rst_i = 1'b0;
    win_start_i = 1'b0;
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_i = 1'b1;

    load_w1();
    run_win(1'b0);
    chk_w1("w1");
    check("w1_type0", 32'(tq_type[0]), 32'(`LEFT_VAL));
    check("w1_val0", tq_val[0], 32'h3F80_0000);
    check("w1_type1", 32'(tq_type[1]), 32'(`RIGHT_VAL));
    check("w1_val1", tq_val[1], 32'hBF80_0000);
    check("w1_type2", 32'(tq_type[2]), 32'(`THRESHOLD));
    check("w1_val2", tq_val[2], 32'h3F00_0000);
    check("w1_thr_events", 32'(nthr), 32'd3);
    check("w1_fs_gap", fs_cyc - thr_cyc, 32'(TL + 2));
    check("w1_overlap", 32'(novl), 32'd0);

    load_w2();
    run_win(1'b0);
    check("w2_face", rface, 32'd0);
    check("w2_stage", rstage, 32'd1);
    check("w2_max_addr", max_addr, 32'd9);
    check("w2_reads", 32'(nrd), 32'd10);
    check("w2_feat_idx", fs_idx_last, 32'd1);

    load_w3();
    run_win(1'b0);
    check("w3_face", rface, 32'd0);
    check("w3_stage", rstage, 32'd2);
    check("w3_feat_starts", 32'(nfs), 32'd3);
    check("w3_feat_idx", fs_idx_last, 32'd2);

    load_w1();
    run_win(1'b1);
    chk_w1("w4");

    load_w2();
    start_win();
    n = 0;
    while (!(feat_start_o && feat_idx_o == 16'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("w5_feat_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) @(negedge clk);
    check("midrst_no_result", 32'(nres), 32'd0);
    rst_i = 1'b1;

    load_w1();
    run_win(1'b0);
    chk_w1("w6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
